hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS pipeline. It sits beside the instruction-decode stage and keeps a three-entry scoreboard of in-flight destination registers for EX, MEM and WB. From that scoreboard it detects read-after-write hazards on the decoding instruction, freezes PC and IF/ID while inserting bubbles into ID/EX, and squashes younger instructions when a branch resolves taken in MEM. It also counts stall and flush events for performance monitoring.

## Interface
Parameters:
- FORWARD, 1, 1 = EX/MEM and MEM/WB forwarding paths exist; 0 = no forwarding.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instruction  in  32  instruction in ID; rs=[25:21], rt=[20:16], rd=[15:11].
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_reg_dst  in  1 each  control-unit outputs for the ID instruction.
- mem_branch_taken  in  1  the branch now in MEM is taken.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- idex_bubble  out  1  load a NOP (all control bits 0) into ID/EX.
- ifid_flush, idex_flush, exmem_flush  out  1 each  zero the control bits of that pipeline register.
- stall_cycles  out  CNT_W  number of cycles with a stall asserted.
- flush_count  out  CNT_W  number of taken-branch flush events.

## Operation
- Scoreboard entries are EX, MEM and WB. Each entry holds {v, rw, mr, dst[4:0]}.
- ID destination: dst = id_reg_dst ? rd : rt. The ID entry is v=id_valid, rw=id_reg_write, mr=id_mem_read.
- Source use:
  - rs is used whenever id_valid=1.
  - rt is used when id_reg_dst | id_mem_write | id_branch.
- Match(stage, src) requires all of: src is used, stage.v=1, stage.rw=1, stage.dst!=0, stage.dst==src.
- Hazard detection:
  - FORWARD=1: hazard = Match(EX) with EX.mr=1 (load-use only).
  - FORWARD=0: hazard = Match(EX) | Match(MEM) | Match(WB). The register file writes at the clock edge while ID reads the old value, so WB counts as a hazard.
- Combinational outputs:
  - flush = mem_branch_taken.
  - stall = hazard & ~flush. Flush takes priority over stall.
  - pc_write = ifid_write = ~stall.
  - idex_bubble = stall.
  - ifid_flush = idex_flush = exmem_flush = flush.
- Scoreboard update on the clock edge:
  - Normal: EX <= ID entry; MEM <= EX; WB <= MEM.
  - Stall: EX <= invalid; MEM <= EX; WB <= MEM.
  - Flush: EX <= invalid; MEM <= invalid; WB <= MEM. The branch itself advances; it has rw=0.
- Counters:
  - stall_cycles increments on every stall cycle.
  - flush_count increments on every flush cycle.
  - Both saturate at all-ones.

## Timing
- Reset values:
  - All scoreboard v=0.
  - pc_write=1, ifid_write=1.
  - idex_bubble=0, all flush outputs 0.
  - Both counters 0.
- Reset asserted mid-stall or mid-flush clears the scoreboard immediately. Outputs return to their reset values in the same cycle, without waiting for a clock edge.
- Hazard-to-output latency is zero cycles; outputs are combinational from the scoreboard and the ID inputs.
- Stall lengths:
  - Load-use with FORWARD=1: exactly 1 stall cycle.
  - FORWARD=0, dependent instruction immediately behind the producer: 3 stall cycles.
  - FORWARD=0, one instruction gap: 2 stall cycles.
  - FORWARD=0, two instruction gap: 1 stall cycle.
- Taken branch: flush outputs are high for the single cycle in which mem_branch_taken=1. Three younger instructions are squashed.
- A stall and a flush in the same cycle: the flush wins, stall=0, and stall_cycles does not increment.
- Writes to $0 never create a hazard.
- id_valid=0 never stalls, and enters EX as an invalid entry.

## Test plan
- FORWARD=1, `lw $2,0($1)` then `add $3,$2,$4` → exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; then `add` proceeds; stall_cycles=1.
- FORWARD=0, `add $5,$1,$1` then `sub $6,$5,$2` → 3 consecutive stall cycles; `sub` enters EX on the 4th cycle; stall_cycles=3.
- FORWARD=0, `addi $0,...` (rt=0) then a reader of $0 → no stall at all.
- `beq` resolving taken in MEM while a load-use hazard exists in ID → ifid_flush, idex_flush and exmem_flush are 1 for one cycle; idex_bubble=0; flush_count=1; stall_cycles is unchanged.
- `sw $7,0($1)` immediately after `lw $7,...` with FORWARD=1 → 1-cycle stall (rt is used by the store).
- Assert reset during the 2nd of 3 FORWARD=0 stall cycles → outputs go to their reset values immediately; both counters read 0; the next dependent-free instruction flows with no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: tracks in-flight destinations
// for EX/MEM/WB, stalls on RAW hazards and squashes younger work on a taken branch.
module hazard_ctrl #(
  parameter int FORWARD = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instruction,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             id_reg_dst,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int NS = 3;  // index 0 = EX, 1 = MEM, 2 = WB
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NS-1:0]      sb_v_reg, sb_rw_reg, sb_mr_reg;
  logic [NS-1:0][4:0] sb_dst_reg;
  logic [NS-1:0]      sb_v_next, sb_rw_next, sb_mr_next;
  logic [NS-1:0][4:0] sb_dst_next;
  logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;

  logic [4:0]    rs, rt, rd, id_dst;
  logic          use_rs, use_rt;
  logic [NS-1:0] match;
  logic          hazard, stall, flush;
  logic          unused_bits;

  assign rs     = id_instruction[25:21];
  assign rt     = id_instruction[20:16];
  assign rd     = id_instruction[15:11];
  assign id_dst = id_reg_dst ? rd : rt;
  assign use_rs = id_valid;
  assign use_rt = id_valid & (id_reg_dst | id_mem_write | id_branch);

  for (genvar gi = 0; gi < NS; gi++) begin : g_match
    assign match[gi] = sb_v_reg[gi] & sb_rw_reg[gi] & (sb_dst_reg[gi] != 5'd0) &
                       ((use_rs & (sb_dst_reg[gi] == rs)) |
                        (use_rt & (sb_dst_reg[gi] == rt)));
  end

  // With forwarding only a load still in EX cannot supply its result in time.
  if (FORWARD != 0) begin : g_fwd
    assign hazard = match[0] & sb_mr_reg[0];
  end else begin : g_nofwd
    assign hazard = |match;
  end

  // Gated by reset so outputs drop to their idle values without a clock edge.
  assign flush = mem_branch_taken & ~reset;
  assign stall = hazard & ~flush & ~reset;

  assign pc_write     = ~stall;
  assign ifid_write   = ~stall;
  assign idex_bubble  = stall;
  assign ifid_flush   = flush;
  assign idex_flush   = flush;
  assign exmem_flush  = flush;
  assign stall_cycles = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;

  assign unused_bits = ^{id_instruction[31:26], id_instruction[10:0], match, sb_mr_reg};

  always_comb begin
    sb_v_next   = {sb_v_reg[1:0], id_valid};
    sb_rw_next  = {sb_rw_reg[1:0], id_reg_write};
    sb_mr_next  = {sb_mr_reg[1:0], id_mem_read};
    sb_dst_next = {sb_dst_reg[1:0], id_dst};
    if (stall || flush) sb_v_next[0] = 1'b0;
    // The instruction leaving EX is younger than the taken branch, so it dies too.
    if (flush) sb_v_next[1] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_v_reg   <= '0;
      sb_rw_reg  <= '0;
      sb_mr_reg  <= '0;
      sb_dst_reg <= '0;
    end else begin
      sb_v_reg   <= sb_v_next;
      sb_rw_reg  <= sb_rw_next;
      sb_mr_reg  <= sb_mr_next;
      sb_dst_reg <= sb_dst_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && stall_cnt_reg != CNT_MAX) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush && flush_cnt_reg != CNT_MAX) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance and a non-forwarding instance with
// narrow counters, driven by directed scenarios and a random stream against a model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_reg_dst;
  logic        mem_branch_taken;

  logic        f_pc_write, f_ifid_write, f_idex_bubble, f_ifid_flush, f_idex_flush, f_exmem_flush;
  logic [15:0] f_stall_cycles, f_flush_count;
  logic        n_pc_write, n_ifid_write, n_idex_bubble, n_ifid_flush, n_idex_flush, n_exmem_flush;
  logic [3:0]  n_stall_cycles, n_flush_count;
  logic [5:0]  f_outs, n_outs;

  int checks = 0;
  int passed = 0;

  // In-flight register writers, aged by pipeline position (0 = EX).
  typedef struct {
    logic [4:0] dst;
    bit         mr;
    int         age;
  } rec_t;
  rec_t mq[2][$];
  int   m_st[2];
  int   m_fl[2];

  always #5 clk = ~clk;

  assign f_outs = {f_pc_write, f_ifid_write, f_idex_bubble, f_ifid_flush, f_idex_flush, f_exmem_flush};
  assign n_outs = {n_pc_write, n_ifid_write, n_idex_bubble, n_ifid_flush, n_idex_flush, n_exmem_flush};

  hazard_ctrl #(.FORWARD(1), .CNT_W(16)) dut_f (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_reg_dst(id_reg_dst), .mem_branch_taken(mem_branch_taken),
    .pc_write(f_pc_write), .ifid_write(f_ifid_write), .idex_bubble(f_idex_bubble),
    .ifid_flush(f_ifid_flush), .idex_flush(f_idex_flush), .exmem_flush(f_exmem_flush),
    .stall_cycles(f_stall_cycles), .flush_count(f_flush_count)
  );

  hazard_ctrl #(.FORWARD(0), .CNT_W(4)) dut_n (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_reg_dst(id_reg_dst), .mem_branch_taken(mem_branch_taken),
    .pc_write(n_pc_write), .ifid_write(n_ifid_write), .idex_bubble(n_idex_bubble),
    .ifid_flush(n_ifid_flush), .idex_flush(n_idex_flush), .exmem_flush(n_exmem_flush),
    .stall_cycles(n_stall_cycles), .flush_count(n_flush_count)
  );

  task automatic set_ins(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic br, input logic rdst, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
    id_valid       = v;
    id_reg_write   = rw;
    id_mem_read    = mr;
    id_mem_write   = mw;
    id_branch      = br;
    id_reg_dst     = rdst;
    id_instruction = {6'h00, rs, rt, rd, 11'h000};
  endtask

  task automatic ins_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_ins(1, 1, 0, 0, 0, 1, rs, rt, rd);
  endtask
  task automatic ins_lw(input logic [4:0] rt, input logic [4:0] rs);
    set_ins(1, 1, 1, 0, 0, 0, rs, rt, 5'd0);
  endtask
  task automatic ins_sw(input logic [4:0] rt, input logic [4:0] rs);
    set_ins(1, 0, 0, 1, 0, 0, rs, rt, 5'd0);
  endtask
  task automatic ins_addi(input logic [4:0] rt, input logic [4:0] rs);
    set_ins(1, 1, 0, 0, 0, 0, rs, rt, 5'd0);
  endtask
  task automatic ins_none();
    set_ins(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_st[m] = 0;
      m_fl[m] = 0;
    end
  endtask

  // m = 0: forwarding (only a load one instruction ahead blocks);
  // m = 1: no forwarding (any writer still in flight blocks its readers).
  function automatic bit model_hz(int m);
    logic [4:0] rs_v, rt_v;
    bit         rt_used;
    if (!id_valid) return 0;
    rs_v    = id_instruction[25:21];
    rt_v    = id_instruction[20:16];
    rt_used = id_reg_dst || id_mem_write || id_branch;
    foreach (mq[m][k]) begin
      if (mq[m][k].dst == rs_v || (rt_used && mq[m][k].dst == rt_v)) begin
        if (m == 1 || (mq[m][k].age == 0 && mq[m][k].mr)) return 1;
      end
    end
    return 0;
  endfunction

  function automatic logic [5:0] exp_outs(int m);
    logic fl, st;
    fl = mem_branch_taken && !reset;
    st = model_hz(m) && !fl && !reset;
    return {!st, !st, st, fl, fl, fl};
  endfunction

  function automatic int sat(int c, int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic advance(int m, bit st, bit fl);
    rec_t nq[$];
    rec_t r;
    logic [4:0] d;
    foreach (mq[m][k]) begin
      if (!(fl && mq[m][k].age == 0) && mq[m][k].age < 2) begin
        r = mq[m][k];
        r.age++;
        nq.push_back(r);
      end
    end
    mq[m] = nq;
    d = id_reg_dst ? id_instruction[15:11] : id_instruction[20:16];
    if (!st && !fl && id_valid && id_reg_write && d != 5'd0) begin
      r.dst = d;
      r.mr  = id_mem_read;
      r.age = 0;
      mq[m].push_back(r);
    end
    if (st) m_st[m]++;
    if (fl) m_fl[m]++;
  endtask

  // Advance one clock: model follows the DUT across the rising edge, returns at the falling edge.
  task automatic step();
    bit fl, sf, sn;
    fl = mem_branch_taken;
    sf = model_hz(0) && !fl;
    sn = model_hz(1) && !fl;
    @(posedge clk);
    advance(0, sf, fl);
    advance(1, sn, fl);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_branch_taken = 1'b0;
    ins_none();
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (f_outs !== 6'b110000) $display("FAIL reset_outs_f: got %b need %b", f_outs, 6'b110000); else passed++;
    checks++; if (n_outs !== 6'b110000) $display("FAIL reset_outs_n: got %b need %b", n_outs, 6'b110000); else passed++;
    checks++; if ({f_stall_cycles, f_flush_count} !== 32'd0) $display("FAIL reset_cnt_f: got %h need 0", {f_stall_cycles, f_flush_count}); else passed++;
    checks++; if ({n_stall_cycles, n_flush_count} !== 8'd0) $display("FAIL reset_cnt_n: got %h need 0", {n_stall_cycles, n_flush_count}); else passed++;
    mem_branch_taken = 1'b1;
    ins_r(3, 3, 3);
    #1;
    checks++; if (f_outs !== 6'b110000) $display("FAIL reset_masks_flush: got %b need %b", f_outs, 6'b110000); else passed++;
    mem_branch_taken = 1'b0;
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ins_lw(2, 1);
    #1;
    checks++; if (f_outs !== 6'b110000) $display("FAIL lu_first: got %b need %b", f_outs, 6'b110000); else passed++;
    step();
    ins_r(3, 2, 4);
    #1;
    checks++; if (f_outs !== 6'b001000) $display("FAIL lu_stall: got %b need %b", f_outs, 6'b001000); else passed++;
    step();
    #1;
    checks++; if (f_outs !== 6'b110000) $display("FAIL lu_release: got %b need %b", f_outs, 6'b110000); else passed++;
    checks++; if (f_stall_cycles !== 16'd1) $display("FAIL lu_count: got %0d need 1", f_stall_cycles); else passed++;
    step();
  endtask

  task automatic test_raw_gap();
    int count;
    for (int gap = 0; gap < 3; gap++) begin
      do_reset();
      ins_r(5, 1, 1);
      step();
      for (int g = 0; g < gap; g++) begin
        ins_none();
        step();
      end
      ins_r(6, 5, 2);
      count = 0;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (!n_idex_bubble) break;
        count++;
        step();
      end
      step();
      checks++; if (count !== 3 - gap) $display("FAIL raw_gap%0d_len: got %0d need %0d", gap, count, 3 - gap); else passed++;
      checks++; if (n_stall_cycles !== 4'(3 - gap)) $display("FAIL raw_gap%0d_cnt: got %0d need %0d", gap, n_stall_cycles, 3 - gap); else passed++;
      if (gap == 0) begin
        ins_r(7, 6, 0);
        #1;
        checks++; if (n_outs !== 6'b001000) $display("FAIL raw_sub_in_ex: got %b need %b", n_outs, 6'b001000); else passed++;
        step();
      end
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    ins_addi(0, 1);
    step();
    ins_r(3, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (n_outs !== 6'b110000) $display("FAIL zero_reg_c%0d: got %b need %b", c, n_outs, 6'b110000); else passed++;
      step();
    end
    checks++; if (n_stall_cycles !== 4'd0) $display("FAIL zero_reg_cnt: got %0d need 0", n_stall_cycles); else passed++;
  endtask

  task automatic test_flush_priority();
    do_reset();
    ins_lw(2, 1);
    step();
    ins_r(3, 2, 4);
    mem_branch_taken = 1'b1;
    #1;
    checks++; if (f_outs !== 6'b110111) $display("FAIL flush_outs_f: got %b need %b", f_outs, 6'b110111); else passed++;
    checks++; if (n_outs !== 6'b110111) $display("FAIL flush_outs_n: got %b need %b", n_outs, 6'b110111); else passed++;
    step();
    mem_branch_taken = 1'b0;
    #1;
    checks++; if (f_outs !== 6'b110000) $display("FAIL flush_after_f: got %b need %b", f_outs, 6'b110000); else passed++;
    checks++; if (n_outs !== 6'b110000) $display("FAIL flush_after_n: got %b need %b", n_outs, 6'b110000); else passed++;
    checks++; if (f_flush_count !== 16'd1) $display("FAIL flush_count: got %0d need 1", f_flush_count); else passed++;
    checks++; if (f_stall_cycles !== 16'd0) $display("FAIL flush_no_stall_cnt: got %0d need 0", f_stall_cycles); else passed++;
    step();
  endtask

  task automatic test_store_after_load();
    do_reset();
    ins_lw(7, 1);
    step();
    ins_sw(7, 1);
    #1;
    checks++; if (f_outs !== 6'b001000) $display("FAIL sw_stall: got %b need %b", f_outs, 6'b001000); else passed++;
    step();
    #1;
    checks++; if (f_outs !== 6'b110000) $display("FAIL sw_release: got %b need %b", f_outs, 6'b110000); else passed++;
    checks++; if (f_stall_cycles !== 16'd1) $display("FAIL sw_count: got %0d need 1", f_stall_cycles); else passed++;
    step();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    ins_r(5, 1, 1);
    step();
    ins_r(6, 5, 2);
    step();
    #1;
    checks++; if (n_outs !== 6'b001000) $display("FAIL rms_second_stall: got %b need %b", n_outs, 6'b001000); else passed++;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (n_outs !== 6'b110000) $display("FAIL rms_outs: got %b need %b", n_outs, 6'b110000); else passed++;
    checks++; if ({n_stall_cycles, n_flush_count} !== 8'd0) $display("FAIL rms_cnt: got %h need 0", {n_stall_cycles, n_flush_count}); else passed++;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    ins_r(8, 9, 10);
    #1;
    checks++; if (n_outs !== 6'b110000) $display("FAIL rms_next: got %b need %b", n_outs, 6'b110000); else passed++;
    step();
    ins_none();
    #1;
    checks++; if (n_stall_cycles !== 4'd0) $display("FAIL rms_cnt_after: got %0d need 0", n_stall_cycles); else passed++;
  endtask

  task automatic test_random();
    logic [5:0] ef, en;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_ins(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      #1;
      ef = exp_outs(0);
      en = exp_outs(1);
      checks++; if (f_outs !== ef) $display("FAIL rnd_outs_f c%0d: got %b need %b", c, f_outs, ef); else passed++;
      checks++; if (n_outs !== en) $display("FAIL rnd_outs_n c%0d: got %b need %b", c, n_outs, en); else passed++;
      checks++;
      if ({f_stall_cycles, f_flush_count} !== {16'(sat(m_st[0], 16)), 16'(sat(m_fl[0], 16))})
        $display("FAIL rnd_cnt_f c%0d: got %0d/%0d need %0d/%0d", c, f_stall_cycles, f_flush_count,
                 sat(m_st[0], 16), sat(m_fl[0], 16));
      else passed++;
      checks++;
      if ({n_stall_cycles, n_flush_count} !== {4'(sat(m_st[1], 4)), 4'(sat(m_fl[1], 4))})
        $display("FAIL rnd_cnt_n c%0d: got %0d/%0d need %0d/%0d", c, n_stall_cycles, n_flush_count,
                 sat(m_st[1], 4), sat(m_fl[1], 4));
      else passed++;
      step();
    end
    mem_branch_taken = 1'b0;
    ins_none();
  endtask

  initial begin
    reset = 1'b1;
    mem_branch_taken = 1'b0;
    ins_none();
    clear_model();
    test_reset();
    test_load_use();
    test_raw_gap();
    test_zero_reg();
    test_flush_priority();
    test_store_after_load();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout need completion");
    $fatal(1);
  end

endmodule
